// File: rtl/regfile_dump_reader_if.sv
// rtl/regfile_dump_reader_if.sv - register-file read port and byte stream bundle for the dump reader
//
// Signals:
//   rd_en    master->slave  read strobe, one cycle per register
//   rd_addr  master->slave  register address presented with rd_en
//   rd_data  slave->master  read data, valid the cycle after rd_en
//   tx_data  master->slave  stream byte
//   tx_valid master->slave  tx_data valid
//   tx_ready slave->master  sink accepts the byte on tx_valid && tx_ready
interface regfile_dump_reader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output rd_en, rd_addr, tx_data, tx_valid,
        input  rd_data, tx_ready
    );

    modport slave (
        input  rd_en, rd_addr, tx_data, tx_valid,
        output rd_data, tx_ready
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - walks every register through a spare read port and streams it as a framed byte stream
//
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   start  request a dump, sampled only while idle
//   busy   frame in progress
//   done   one-cycle pulse after the checksum byte is accepted
//   bus    register read port (rd_en/rd_addr/rd_data) and byte stream (tx_data/tx_valid/tx_ready)
//
// Frame: HEADER, 4 bytes per register MSB first, then XOR of all data bytes.
module regfile_dump_reader #(
    parameter int         NUM_REGS = 32,
    parameter int         ADDR_W   = 5,
    parameter int         DATA_W   = 32,
    parameter logic [7:0] HEADER   = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    regfile_dump_reader_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_READ,
        S_CAPT,
        S_SEND,
        S_CHK
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [7:0]        chk_q, chk_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic              done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            chk_q      <= '0;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            chk_q      <= chk_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        chk_d        = chk_q;
        shift_d      = shift_q;
        byte_cnt_d   = byte_cnt_q;
        done_d       = 1'b0;
        bus.rd_en    = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_HDR;
                    idx_d   = '0;
                    chk_d   = '0;
                end
            end
            S_HDR: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = HEADER;
                if (bus.tx_ready) state_d = S_READ;
            end
            S_READ: begin
                bus.rd_en = 1'b1;
                state_d   = S_CAPT;
            end
            S_CAPT: begin
                // Read data is captured once here, so stalls in SEND never re-read the file.
                shift_d    = bus.rd_data;
                byte_cnt_d = '0;
                state_d    = S_SEND;
            end
            S_SEND: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = shift_q[DATA_W-1 -: 8];
                if (bus.tx_ready) begin
                    chk_d      = chk_q ^ shift_q[DATA_W-1 -: 8];
                    shift_d    = shift_q << 8;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = S_CHK;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = S_READ;
                        end
                    end
                end
            end
            S_CHK: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = chk_q;
                if (bus.tx_ready) begin
                    state_d = S_IDLE;
                    idx_d   = '0;  // rd_addr reads 0 whenever idle
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.rd_addr = idx_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
endmodule
